// File: rtl/fproc_lut_cfg.sv
// Double-buffered configuration store for the FPROC measurement LUT: the host fills the
// shadow bank, and a commit swaps banks once the LUT is idle, then copies the live bank back.
module fproc_lut_cfg #(
    parameter int N_CORES = 5,
    parameter int N_MEAS  = N_CORES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr_en,
    input  logic [N_MEAS:0]    cfg_wr_addr,
    input  logic [N_CORES-1:0] cfg_wr_data,
    output logic               cfg_wr_ready,
    input  logic               cfg_commit,
    output logic               cfg_commit_done,
    output logic               cfg_err,
    input  logic               cfg_err_clr,
    input  logic               lut_busy,
    input  logic [N_MEAS-1:0]  lut_rd_addr,
    output logic [N_CORES-1:0] lut_rd_data,
    output logic [N_CORES-1:0] lut_mask,
    output logic               bank_sel,
    output logic [1:0]         dbg_state
);

    localparam int DEPTH = 1 << N_MEAS;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMMIT_WAIT = 2'd1,
        COPY        = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                bank_q, bank_d;
    logic [N_MEAS-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_ok;
    logic                err_set;
    logic                shd_sel;

    logic [N_CORES-1:0]  mem_q  [2][DEPTH];
    logic [N_CORES-1:0]  mask_q [2];

    // Host write handshake: a write is taken on any edge where cfg_wr_en and cfg_wr_ready
    // are both high; cfg_wr_en with cfg_wr_ready low is dropped and flagged in cfg_err.
    assign wr_ok   = cfg_wr_en && (state_q == IDLE);
    assign err_set = (state_q != IDLE) && (cfg_wr_en || cfg_commit);
    assign shd_sel = ~bank_q;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_commit) begin
                    state_d = COMMIT_WAIT;
                end
            end
            COMMIT_WAIT: begin
                // Swapping only while the LUT is idle keeps every lookup single-bank.
                if (!lut_busy) begin
                    bank_d  = ~bank_q;
                    cnt_d   = '0;
                    state_d = COPY;
                end
            end
            COPY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {N_MEAS{1'b1}}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (cfg_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Host writes and copy-back are mutually exclusive by state, so one port per bank suffices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                mask_q[b] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (cfg_wr_addr[N_MEAS]) begin
                mask_q[shd_sel] <= cfg_wr_data;
            end else begin
                mem_q[shd_sel][cfg_wr_addr[N_MEAS-1:0]] <= cfg_wr_data;
            end
        end else if (state_q == COPY) begin
            mem_q[shd_sel][cnt_q] <= mem_q[bank_q][cnt_q];
            if (cnt_q == '0) begin
                mask_q[shd_sel] <= mask_q[bank_q];
            end
        end
    end

    assign cfg_wr_ready    = (state_q == IDLE);
    assign cfg_commit_done = done_q;
    assign cfg_err         = err_q;
    assign lut_rd_data     = mem_q[bank_q][lut_rd_addr];
    assign lut_mask        = mask_q[bank_q];
    assign bank_sel        = bank_q;
    assign dbg_state       = state_q;

endmodule
